// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the elastic pipeline stage
// Purpose: occupancy state encoding, depth constant and per-stage
// control bundle layouts used at each inter-stage boundary.
package pipe_pkg;

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_MAX_OCC = 2;

    // Decode -> execute control bundle (14 bits).
    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic [3:0] wa3;
        logic       reg_write;
        logic       plus_one;
        logic       branch_taken;
        logic       pcsrc;
        logic       alu_src;
        logic       mem_to_reg;
    } de_ctrl_t;

    // Execute -> memory control bundle.
    typedef struct packed {
        logic [3:0] wa3;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
    } em_ctrl_t;

    // Memory -> writeback control bundle.
    typedef struct packed {
        logic [3:0] wa3;
        logic       reg_write;
        logic       mem_to_reg;
    } mw_ctrl_t;

    function automatic logic [1:0] occ_of(input pipe_state_e s);
        return logic'(s == PS_FULL) ? 2'(PIPE_MAX_OCC) : ((s == PS_ONE) ? 2'd1 : 2'd0);
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one payload+control entry register
// Purpose: W-bit storage with load enable, cleared asynchronously by rst.
// Ports: clk, rst (async clear, active-high), ld_i (load), d_i (next
// value), q_o (held value).
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= '0;
        end else if (ld_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline register with flush
// Purpose: carries one DATA_W payload and one CTRL_W control bundle between
// pipeline stages; SKID=1 gives a two-entry skid buffer with registered
// in_ready, SKID=0 a single entry with combinational in_ready.
// Ports: clk, rst (async, active-high), flush (drop all held beats and the
// current input beat), in_valid/in_ready/in_data/in_ctrl (upstream),
// out_valid/out_ready/out_data/out_ctrl (downstream head), occupancy (0..2).
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 96,
    parameter int CTRL_W      = 16,
    parameter bit SKID        = 1'b1,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam int W = DATA_W + CTRL_W;

    pipe_state_e state_q, state_d;
    logic         in_xfer, out_xfer;
    logic         head_ld, skid_ld;
    logic [W-1:0] beat_in, head_d, head_q, skid_q;

    assign beat_in   = {in_ctrl, in_data};
    assign out_valid = (state_q != PS_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_ld = 1'b0;
        skid_ld = 1'b0;
        head_d  = beat_in;
        if (flush) begin
            state_d = PS_EMPTY;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (in_xfer) begin
                        state_d = PS_ONE;
                        head_ld = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_ld = 1'b1;
                    end else if (in_xfer && SKID) begin
                        state_d = PS_FULL;
                        skid_ld = 1'b1;
                    end else if (out_xfer) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_xfer) begin
                        state_d = PS_ONE;
                        head_ld = 1'b1;
                        head_d  = skid_q;
                    end
                end
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_entry_reg #(.W(W)) u_head (
        .clk  (clk),
        .rst  (rst),
        .ld_i (head_ld),
        .d_i  (head_d),
        .q_o  (head_q)
    );

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;

            // Registered ready: decided from the next state so the
            // upstream never sees a combinational path from out_ready.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= (state_d != PS_FULL);
                end
            end
            assign in_ready = in_ready_q;

            pipe_entry_reg #(.W(W)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .ld_i (skid_ld),
                .d_i  (beat_in),
                .q_o  (skid_q)
            );
        end else begin : g_single
            logic unused_skid_ld;
            assign unused_skid_ld = skid_ld;
            assign in_ready       = ~rst & (~out_valid | out_ready);
            assign skid_q         = '0;
        end
    endgenerate

    // Bubbles present zero control so stray write enables cannot leak.
    assign {out_ctrl, out_data} = (ZERO_BUBBLE && !out_valid) ? '0 : head_q;
    assign occupancy            = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for both SKID variants
module tb_pipe_stage_elastic;

    localparam int DW = 96;
    localparam int CW = 16;
    localparam int BW = DW + CW;
    typedef logic [BW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [CW-1:0] out_ctrl1, out_ctrl0;
    logic [1:0]    occ1, occ0;

    int checks = 0;
    int errors = 0;

    beat_t q1[$];
    beat_t q0[$];
    bit    rdy1;
    bit    a1, a0;
    bit    acc;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .ZERO_BUBBLE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1),
        .occupancy(occ1)
    );

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .ZERO_BUBBLE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
        .occupancy(occ0)
    );

    task automatic chk(input string nm, input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each stage is a FIFO of at most 2 (SKID=1) or 1
    // (SKID=0) beats; acceptance follows the ready rules of each mode.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q1.delete();
            q0.delete();
            rdy1 = 1'b0;
        end else begin
            a1 = in_valid && rdy1 && !flush;
            a0 = in_valid && (q0.size() == 0 || out_ready) && !flush;
            if (out_ready && q1.size() > 0) void'(q1.pop_front());
            if (out_ready && q0.size() > 0) void'(q0.pop_front());
            if (a1) q1.push_back({in_ctrl, in_data});
            if (a0) q0.push_back({in_ctrl, in_data});
            if (flush) begin
                q1.delete();
                q0.delete();
            end
            rdy1 = (q1.size() < 2);
        end
    end

    // Monitor: compares what each DUT presents against the model head.
    initial forever begin
        @(negedge clk);
        chk("ov1",  beat_t'(out_valid1), beat_t'(q1.size() != 0));
        chk("out1", {out_ctrl1, out_data1}, (q1.size() != 0) ? q1[0] : '0);
        chk("occ1", beat_t'(occ1), beat_t'(q1.size()));
        chk("rdy1", beat_t'(in_ready1), beat_t'(rdy1));
        chk("ov0",  beat_t'(out_valid0), beat_t'(q0.size() != 0));
        chk("out0", {out_ctrl0, out_data0}, (q0.size() != 0) ? q0[0] : '0);
        chk("occ0", beat_t'(occ0), beat_t'(q0.size()));
        chk("rdy0", beat_t'(in_ready0), beat_t'(!rst && (q0.size() == 0 || out_ready)));
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Hold a beat until the SKID=1 stage takes it (bounded).
    task automatic offer(input logic [DW-1:0] d, input int budget);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = d[CW-1:0] ^ 16'h5a5a;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            got = in_ready1;
            nxt();
        end
        chk("offer_accepted", beat_t'(got), beat_t'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_rdy_low", beat_t'(in_ready1), beat_t'(0));
        chk("rst_ov",      beat_t'(out_valid1), beat_t'(0));
        chk("rst_out",     {out_ctrl1, out_data1}, '0);
        chk("rst_occ",     beat_t'(occ1), beat_t'(0));
        nxt();
        chk("rst_rdy_rise", beat_t'(in_ready1), beat_t'(1));

        // Streaming at one beat per cycle.
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(k);
            in_ctrl  = CW'(k);
            nxt();
            chk("stream_data", beat_t'(out_data1), beat_t'(k));
            chk("stream_occ",  beat_t'(occ1), beat_t'(1));
        end
        in_valid = 1'b0;
        nxt();

        // Backpressure fills the skid entry.
        out_ready = 1'b0;
        offer(DW'('hA), 4);
        offer(DW'('hB), 4);
        in_valid = 1'b1; in_data = DW'('hC); in_ctrl = 16'h5a5a ^ 16'hC;
        repeat (3) nxt();
        chk("bp_occ",  beat_t'(occ1), beat_t'(2));
        chk("bp_rdy",  beat_t'(in_ready1), beat_t'(0));
        chk("bp_head", beat_t'(out_data1), beat_t'('hA));
        out_ready = 1'b1;
        offer(DW'('hC), 4);
        repeat (3) nxt();

        // Flush with a full buffer drops everything, including 0xD.
        out_ready = 1'b0;
        offer(DW'('h11), 4);
        offer(DW'('h12), 4);
        chk("fl_pre_occ", beat_t'(occ1), beat_t'(2));
        in_valid = 1'b1; in_data = DW'('hD); in_ctrl = 16'h00DD; flush = 1'b1;
        nxt();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_ov",  beat_t'(out_valid1), beat_t'(0));
        chk("fl_out", {out_ctrl1, out_data1}, '0);
        chk("fl_occ", beat_t'(occ1), beat_t'(0));
        chk("fl_rdy", beat_t'(in_ready1), beat_t'(1));

        // Simultaneous in/out transfer while holding one beat.
        offer(DW'('h5), 4);
        in_valid = 1'b1; in_data = DW'('h6); in_ctrl = 16'h0006; out_ready = 1'b1;
        nxt();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("sim_data1", beat_t'(out_data1), beat_t'('h6));
        chk("sim_occ1",  beat_t'(occ1), beat_t'(1));
        chk("sim_data0", beat_t'(out_data0), beat_t'('h6));
        chk("sim_occ0",  beat_t'(occ0), beat_t'(1));
        out_ready = 1'b1;
        repeat (2) nxt();

        // Asynchronous reset between edges with two beats held.
        out_ready = 1'b0;
        offer(DW'('h21), 4);
        offer(DW'('h22), 4);
        #1 rst = 1'b1;
        #1;
        chk("ar_ov1",  beat_t'(out_valid1), beat_t'(0));
        chk("ar_out1", {out_ctrl1, out_data1}, '0);
        chk("ar_occ1", beat_t'(occ1), beat_t'(0));
        chk("ar_rdy1", beat_t'(in_ready1), beat_t'(0));
        chk("ar_ov0",  beat_t'(out_valid0), beat_t'(0));
        chk("ar_out0", {out_ctrl0, out_data0}, '0);
        #1 rst = 1'b0;

        // Randomised traffic; a held beat stays stable until taken.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready1;
            nxt();
            if (!in_valid || acc || flush) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = {$urandom, $urandom, $urandom};
                in_ctrl  = CW'($urandom);
            end
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(39) == 0);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed decode/execute pipeline register.
- Carries one datapath word plus one packed control bundle between any two pipeline stages, using valid/ready handshake, flush and an optional skid buffer.
- Every inter-stage boundary (fetch/decode, decode/execute, execute/memory, memory/writeback) is built from this one block, so stalls and branch flushes propagate without per-stage hand-coding.
- Control bits of a bubble are forced to zero so write enables cannot leak.

Parameters:
- DATA_W, 96: width of the datapath payload (e.g. regA, regB, ext concatenated).
- CTRL_W, 16: width of the packed control bundle (ALU control, write address, enables).
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.
- ZERO_BUBBLE, 1: 1 forces out_data and out_ctrl to 0 while out_valid=0; 0 leaves the last value visible.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  discard all held entries; the current input beat is also discarded
- in_valid  in  1  upstream beat valid
- in_ready  out  1  this stage can accept a beat
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  beat available downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head payload
- out_ctrl  out  CTRL_W  head control bundle
- occupancy  out  2  number of held entries (0..2)

Behaviour:
- Reset values (asynchronous on rst=1):
  - state EMPTY; all entries cleared.
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - in_ready=0.
  - SKID=1: in_ready rises on the first rising clk edge after rst deasserts.
  - SKID=0: in_ready may rise combinationally once rst is low.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready at a rising edge.
  - Output transfer occurs when out_valid & out_ready at a rising edge.
  - Ordering is strictly FIFO.
- Latency: a beat accepted at edge N is presented on out_* after edge N. No combinational in→out path in either mode.
- SKID=1 state machine on state {EMPTY, ONE, FULL}:
  - EMPTY + in_xfer → ONE.
  - ONE + in_xfer & !out_xfer → FULL.
  - ONE + out_xfer & !in_xfer → EMPTY.
  - ONE + both → ONE (head replaced by the incoming beat).
  - FULL + out_xfer → ONE (skid entry moves to head).
  - in_ready is registered: high in the next cycle iff the next state is not FULL.
  - Sustains 1 beat/cycle with no combinational ready path.
- SKID=0:
  - Single entry; in_ready = !out_valid | out_ready.
  - occupancy ≤ 1; FULL is never reached.
- Flush:
  - Highest priority after rst.
  - At an edge with flush=1: state → EMPTY, occupancy → 0, out_valid=0 after the edge.
  - The in_valid beat present that cycle is dropped even if in_ready=1; out_xfer in that cycle is still considered taken by downstream.
  - SKID=1: in_ready=1 in the cycle after the flush.
- Bubble: with ZERO_BUBBLE=1, out_data/out_ctrl are 0 whenever out_valid=0, including after flush and reset.
- Stability: while out_valid=1 & out_ready=0, out_data/out_ctrl/out_valid hold unchanged.
- Upstream rule: the bench asserts that in_data/in_ctrl are stable while in_valid=1 & in_ready=0. The block does not depend on it.
- Simultaneous events:
  - rst dominates flush; flush dominates both transfers.
  - in_xfer and out_xfer in the same cycle leave occupancy unchanged.
- Reset mid-operation: all held beats are lost, outputs go to reset values immediately (asynchronously), with no partial output.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] pipe_state_e {PS_EMPTY, PS_ONE, PS_FULL}.
  - Constant PIPE_MAX_OCC=2.
  - Packed struct typedefs for each stage's control bundle (e.g. de_ctrl_t: alu_ctrl[3:0], wa3[3:0], reg_write, plus_one, branch_taken, pcsrc, alu_src, mem_to_reg).
- One sub-module, pipe_entry_reg: a single DATA_W+CTRL_W register with load enable and async clear.
  - Instantiated once for the head and, under SKID=1, once for the skid entry.

Test Plan:
- Reset release, SKID=1: rst 1→0, in_valid=0 → in_ready=0 until the first edge, then 1; out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
- Streaming: in_valid=1 with data 0x1..0x8 on consecutive cycles, out_ready=1 → out_data 0x1..0x8 one cycle later, one per cycle, no gaps, occupancy stays 1.
- Backpressure, SKID=1: out_ready=0 while beats 0xA, 0xB, 0xC are offered:
  - 0xA and 0xB are accepted; occupancy=2; in_ready=0; 0xC is held upstream.
  - out_data holds 0xA.
  - With out_ready=1, outputs are 0xA, 0xB, 0xC in order.
- Flush with full buffer: occupancy=2, flush=1 with in_valid=1, in_data=0xD → next cycle out_valid=0, out_data=0, out_ctrl=0, occupancy=0; 0xD never appears at the output.
- Simultaneous transfer in ONE, SKID=0 and SKID=1: head 0x5 with out_ready=1, in_valid=1, in_data=0x6 → next cycle out_data=0x6, occupancy=1.
- Async reset mid-stream: rst pulsed between edges while occupancy=2 → outputs go to zero immediately without a clock edge; the stream restarts cleanly after release.
